// File: rtl/pe_stage_seq.sv
// pe_stage_seq
// Stage sequencer for the RSA datapath. Accepts one one-hot EKF stage request
// (PRD/NEW/UPD), optionally runs a nonlinear-unit handshake on that stage's
// channel, then runs cfg_nsteps systolic matrix steps. Each step is a load
// cycle, a skew-aware feed window and a drain/writeback window.
//
// Ports:
//   clk, sys_rst_n          clock, asynchronous active-low reset
//   stage_val / stage_rdy   stage request (one-hot) / ready, high only in IDLE
//   stage_done              one-cycle pulse of the finished stage bit
//   err_onehot              one-cycle pulse after a multi-hot request seen in IDLE
//   nl_m_val / nl_m_rdy     nonlinear request to the nonlinear unit
//   nl_s_val / nl_s_rdy     nonlinear result back from the nonlinear unit
//   cfg_nsteps              step count, sampled on accept
//   cfg_n                   inner dimension of the current step, sampled in STEP_LD
//   cur_stage, step_idx     latched stage (0 in IDLE) and 0-based step index
//   feed_en, feed_cnt       feed window and cycle index within it
//   drain_en, wb_en         read-drain and writeback windows
//   state_dbg               current FSM state encoding
//
// Handshakes: a transfer happens on a rising clk edge where the valid and the
// ready of the same channel are both high. The sequencer's valid/ready
// outputs are decoded from registered state only, so they never depend
// combinationally on the partner's signals; nl_m_val holds until accepted and
// nl_s_rdy holds until the result arrives.
module pe_stage_seq #(
  parameter int X        = 4,
  parameter int Y        = 4,
  parameter int N_STAGE  = 3,
  parameter int STEP_W   = 3,
  parameter int DIM_W    = 8,
  parameter int RD_DELAY = 3,
  parameter int WR_DELAY = 1,
  parameter logic [N_STAGE-1:0] NL_MASK = 3'b011
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic [N_STAGE-1:0] stage_val,
  output logic               stage_rdy,
  output logic [N_STAGE-1:0] stage_done,
  output logic               err_onehot,
  output logic [N_STAGE-1:0] nl_m_val,
  input  logic [N_STAGE-1:0] nl_m_rdy,
  input  logic [N_STAGE-1:0] nl_s_val,
  output logic [N_STAGE-1:0] nl_s_rdy,
  input  logic [STEP_W-1:0]  cfg_nsteps,
  input  logic [DIM_W-1:0]   cfg_n,
  output logic [N_STAGE-1:0] cur_stage,
  output logic [STEP_W-1:0]  step_idx,
  output logic               feed_en,
  output logic [DIM_W:0]     feed_cnt,
  output logic               drain_en,
  output logic               wb_en,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    NL_REQ  = 3'd1,
    NL_WAIT = 3'd2,
    STEP_LD = 3'd3,
    FEED    = 3'd4,
    DRAIN   = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam int D_TOT = RD_DELAY + WR_DELAY;
  localparam int DCW   = $clog2(D_TOT + 1);
  localparam logic [DCW-1:0] D_LAST = DCW'(D_TOT - 1);
  localparam logic [DCW-1:0] RD_LIM = DCW'(RD_DELAY);
  // Skew of the array: the last operand reaches the far corner X+Y-2 cycles late.
  localparam logic [DIM_W:0] SKEW = (DIM_W + 1)'(X + Y - 2);

  state_t             state_q, state_d;
  logic [N_STAGE-1:0] cur_q;
  logic [STEP_W-1:0]  nsteps_q;
  logic [STEP_W-1:0]  step_q;
  logic [DIM_W-1:0]   n_eff_q;
  logic [DIM_W:0]     feed_cnt_q;
  logic [DCW-1:0]     dcnt_q;
  logic               err_q;

  logic               onehot;
  logic               multihot;
  logic [DIM_W:0]     len;
  logic               feed_last;
  logic               drain_last;
  logic               last_step;

  assign onehot     = (stage_val != '0) && ((stage_val & (stage_val - 1'b1)) == '0);
  assign multihot   = (stage_val != '0) && !onehot;
  // One extra bit so n_eff + skew never wraps.
  assign len        = {1'b0, n_eff_q} + SKEW;
  assign feed_last  = (feed_cnt_q == len - 1'b1);
  assign drain_last = (dcnt_q == D_LAST);
  assign last_step  = (step_q == nsteps_q - 1'b1);

  // State register
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (onehot) begin
          if ((stage_val & NL_MASK) != '0) state_d = NL_REQ;
          else if (cfg_nsteps == '0)       state_d = DONE;
          else                             state_d = STEP_LD;
        end
      end
      NL_REQ:  if ((nl_m_rdy & cur_q) != '0) state_d = NL_WAIT;
      NL_WAIT: begin
        if ((nl_s_val & cur_q) != '0) state_d = (nsteps_q == '0) ? DONE : STEP_LD;
      end
      STEP_LD: state_d = FEED;
      FEED:    if (feed_last) state_d = DRAIN;
      DRAIN:   if (drain_last) state_d = last_step ? DONE : STEP_LD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cur_q      <= '0;
      nsteps_q   <= '0;
      step_q     <= '0;
      n_eff_q    <= '0;
      feed_cnt_q <= '0;
      dcnt_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= (state_q == IDLE) && multihot;
      case (state_q)
        IDLE: begin
          if (onehot) begin
            cur_q    <= stage_val;
            nsteps_q <= cfg_nsteps;
            step_q   <= '0;
          end
        end
        STEP_LD: begin
          // A zero dimension still needs one feed beat to flush the skew.
          n_eff_q    <= (cfg_n == '0) ? DIM_W'(1) : cfg_n;
          feed_cnt_q <= '0;
        end
        FEED: begin
          if (feed_last) begin
            feed_cnt_q <= '0;
            dcnt_q     <= '0;
          end else begin
            feed_cnt_q <= feed_cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_last) begin
            dcnt_q <= '0;
            if (!last_step) step_q <= step_q + 1'b1;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        DONE: begin
          cur_q  <= '0;
          step_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs: decoded from registered state only
  always_comb begin
    stage_rdy  = 1'b0;
    stage_done = '0;
    nl_m_val   = '0;
    nl_s_rdy   = '0;
    feed_en    = 1'b0;
    drain_en   = 1'b0;
    wb_en      = 1'b0;
    case (state_q)
      IDLE:    stage_rdy  = 1'b1;
      NL_REQ:  nl_m_val   = cur_q;
      NL_WAIT: nl_s_rdy   = cur_q;
      FEED:    feed_en    = 1'b1;
      DRAIN: begin
        drain_en = (dcnt_q < RD_LIM);
        wb_en    = (dcnt_q >= RD_LIM);
      end
      DONE:    stage_done = cur_q;
      default: ;
    endcase
  end

  assign err_onehot = err_q;
  assign cur_stage  = cur_q;
  assign step_idx   = step_q;
  assign feed_cnt   = feed_cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pe_stage_seq.sv
// Directed bench for pe_stage_seq (default parameters: X=Y=4, RD=3, WR=1).
// Inputs change on the falling edge or #1 after the rising edge; outputs are
// sampled on the falling edge. Cycle 1 is the first cycle after the accept edge.
module tb_pe_stage_seq;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic [2:0] stage_val, nl_m_rdy, nl_s_val, cfg_nsteps;
  logic [7:0] cfg_n;
  logic       stage_rdy, err_onehot, feed_en, drain_en, wb_en;
  logic [2:0] stage_done, nl_m_val, nl_s_rdy, cur_stage, step_idx, state_dbg;
  logic [8:0] feed_cnt;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  bit feed_seen = 1'b0;

  localparam logic [31:0] IDLE_VEC = {13'd0, 1'b1, 18'd0};

  always #5 clk = ~clk;

  pe_stage_seq dut (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .stage_val(stage_val), .stage_rdy(stage_rdy), .stage_done(stage_done),
    .err_onehot(err_onehot),
    .nl_m_val(nl_m_val), .nl_m_rdy(nl_m_rdy), .nl_s_val(nl_s_val), .nl_s_rdy(nl_s_rdy),
    .cfg_nsteps(cfg_nsteps), .cfg_n(cfg_n),
    .cur_stage(cur_stage), .step_idx(step_idx),
    .feed_en(feed_en), .feed_cnt(feed_cnt), .drain_en(drain_en), .wb_en(wb_en),
    .state_dbg(state_dbg)
  );

  always @(negedge clk) begin
    if (stage_done != 3'b000) done_cnt++;
    if (feed_en) feed_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {13'd0, stage_rdy, stage_done, cur_stage, feed_en, feed_cnt, drain_en, wb_en};
  endfunction

  // Expected outputs k cycles after the first STEP_LD of a stage.
  // Each step: 1 load cycle, len feed cycles, 3 drain cycles, 1 writeback cycle.
  function automatic logic [31:0] exp_vec(input logic [2:0] stg, input int ns, input int len,
                                          input int k);
    int p_len;
    int p;
    logic rdy;
    logic [2:0] done;
    logic [2:0] cur;
    logic fe, dr, wb;
    logic [8:0] cnt;
    p_len = len + 5;
    rdy = 1'b0; done = 3'b000; cur = 3'b000; fe = 1'b0; dr = 1'b0; wb = 1'b0; cnt = 9'd0;
    if (k < ns * p_len) begin
      p   = k % p_len;
      cur = stg;
      if (p >= 1 && p <= len) begin
        fe  = 1'b1;
        cnt = 9'(p - 1);
      end
      if (p > len && p <= len + 3) dr = 1'b1;
      if (p == len + 4) wb = 1'b1;
    end else if (k == ns * p_len) begin
      done = stg;
      cur  = stg;
    end else begin
      rdy = 1'b1;
    end
    return {13'd0, rdy, done, cur, fe, cnt, dr, wb};
  endfunction

  task automatic accept(input logic [2:0] stg, input logic [2:0] ns, input logic [7:0] n);
    @(negedge clk);
    stage_val  = stg;
    cfg_nsteps = ns;
    cfg_n      = n;
    @(posedge clk);
    #1 stage_val = 3'b000;
  endtask

  // Samples cycles c_from..c_to; off is the cycle of the first STEP_LD.
  task automatic run_steps(input logic [2:0] stg, input int ns, input int len,
                           input int off, input int c_from, input int c_to);
    int k;
    for (int c = c_from; c <= c_to; c++) begin
      @(negedge clk);
      k = c - off;
      check($sformatf("s%0h_c%0d", stg, c), obs_vec(), exp_vec(stg, ns, len, k));
      if (k < ns * (len + 5))
        check($sformatf("s%0h_step_c%0d", stg, c), 32'(step_idx), 32'(k / (len + 5)));
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    stage_val = 3'b000; nl_m_rdy = 3'b000; nl_s_val = 3'b000;
    cfg_nsteps = 3'd0; cfg_n = 8'd0;

    // Reset values
    #3;
    check("rst_vec", obs_vec(), IDLE_VEC);
    check("rst_misc", {err_onehot, nl_m_val, nl_s_rdy, step_idx}, 32'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;

    // UPD, 2 steps, n=3 -> len 9, done at cycle 29, ready at 30
    accept(3'b100, 3'd2, 8'd3);
    run_steps(3'b100, 2, 9, 1, 1, 30);

    // PRD with NL handshake; nl_m_rdy[1] asserted during NL_REQ must be ignored
    accept(3'b001, 3'd1, 8'd0);
    nl_m_rdy = 3'b010;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("prd_nlreq_c%0d", c), {stage_rdy, nl_m_val, nl_s_rdy}, {1'b0, 3'b001, 3'b000});
    end
    nl_m_rdy = 3'b001;
    @(negedge clk);
    check("prd_nlwait_c4", {nl_m_val, nl_s_rdy}, {3'b000, 3'b001});
    nl_m_rdy = 3'b000;
    @(negedge clk);
    check("prd_nlwait_c5", {nl_m_val, nl_s_rdy}, {3'b000, 3'b001});
    nl_s_val = 3'b001;
    @(posedge clk);
    #1 nl_s_val = 3'b000;
    // n_eff=1 -> len 7; STEP_LD at cycle 6, done at 18
    run_steps(3'b001, 1, 7, 6, 6, 19);

    // Multi-hot request: error pulse every cycle, stays in IDLE
    @(negedge clk);
    stage_val = 3'b011;
    @(negedge clk);
    check("mh_err1", 32'(err_onehot), 32'd1);
    check("mh_vec1", obs_vec(), IDLE_VEC);
    check("mh_state1", 32'(state_dbg), 32'd0);
    @(negedge clk);
    check("mh_err2", 32'(err_onehot), 32'd1);
    stage_val = 3'b000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("zero_c%0d", c), {err_onehot, obs_vec()}, {1'b0, IDLE_VEC});
    end

    // NEW with 0 steps: zero-wait NL handshake, done at cycle 3, no feed
    feed_seen = 1'b0;
    accept(3'b010, 3'd0, 8'd5);
    @(negedge clk);
    check("new_nlreq", 32'(nl_m_val), 32'b010);
    nl_m_rdy = 3'b010;
    @(negedge clk);
    check("new_nlwait", {nl_m_val, nl_s_rdy}, {3'b000, 3'b010});
    nl_m_rdy = 3'b000;
    nl_s_val = 3'b010;
    @(negedge clk);
    check("new_done", {stage_rdy, stage_done}, {1'b0, 3'b010});
    nl_s_val = 3'b000;
    @(negedge clk);
    check("new_idle", obs_vec(), IDLE_VEC);
    check("new_nofeed", 32'(feed_seen), 32'd0);

    // UPD with a stray request during FEED, then async reset in step 1 FEED
    accept(3'b100, 3'd2, 8'd3);
    run_steps(3'b100, 2, 9, 1, 1, 4);
    stage_val = 3'b001;
    @(posedge clk);
    #1 stage_val = 3'b000;
    run_steps(3'b100, 2, 9, 1, 5, 20);
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_vec", obs_vec(), IDLE_VEC);
    check("arst_misc", {err_onehot, nl_m_val, nl_s_rdy, step_idx, state_dbg}, 32'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;

    // Fresh UPD after reset: 1 step, n=2 -> len 8, done at cycle 14
    accept(3'b100, 3'd1, 8'd2);
    run_steps(3'b100, 1, 8, 1, 1, 15);

    // Four requests completed; the aborted one and the stray pulse produce no done
    check("done_cnt", 32'(done_cnt), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
